tlc5620_ch_sched: RTL and testbench

Round-robin scheduler and serializer that shares the single TLC5620 quad 8-bit serial DAC among four channel requesters.
- Each requester posts an 8-bit code and a range bit with a req/ack handshake.
- The block grants one requester at a time and shifts an 11-bit frame (A1 A0 RNG D7..D0, MSB first) onto the DAC pins, then pulses LOAD.
- Sits between the waveform/code generators and the DAC pins. Exports the last code written per channel for the BCD/7-segment display path.

---
 rtl/tlc5620_pkg.sv | 48 ++++
 rtl/tlc5620_rr_arb4.sv | 40 ++++
 rtl/tlc5620_ch_sched.sv | 193 +++++++++++++++++++
 tb/tb_tlc5620_ch_sched.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc5620_pkg.sv
// -----------------------------------------------------------------------------
// tlc5620_pkg
// Shared types and constants for the TLC5620 channel scheduler.
//   state_e        : scheduler FSM states (ST_LDAC only with TLC5620_SIMUL_UPDATE_EN)
//   FRAME_BITS     : bits per DAC frame (A1 A0 RNG D7..D0)
//   NUM_CH         : number of DAC channels / requesters
//   CH_A..CH_D     : DAC channel addresses
//   BIT_CNT_W      : width of the in-frame bit counter
//   pack_frame()   : builds the 11-bit frame, MSB shifted first
//   onehot_to_idx(): converts a one-hot grant into a channel index
// -----------------------------------------------------------------------------
package tlc5620_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD,
        ST_GAP
`ifdef TLC5620_SIMUL_UPDATE_EN
        , ST_LDAC
`endif
    } state_e;

    localparam int FRAME_BITS = 11;
    localparam int NUM_CH     = 4;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [1:0] addr,
                                                        input logic       rng,
                                                        input logic [7:0] code);
        return {addr, rng, code};
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) idx = idx | 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tlc5620_rr_arb4.sv
// -----------------------------------------------------------------------------
// tlc5620_rr_arb4
// Combinational 4-way round-robin arbiter. The search starts one above the
// last winner (ptr_i) and wraps, so the last winner has the lowest priority.
// Ports:
//   req_i   [3:0] : pending requests
//   ptr_i   [1:0] : index of the previous winner
//   gnt_o   [3:0] : one-hot grant (all zero when nothing is pending)
//   valid_o       : at least one request is pending
// -----------------------------------------------------------------------------
module tlc5620_rr_arb4
    import tlc5620_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [1:0]        ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic              valid_o
);

    logic [1:0] idx;
    logic       found;

    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        // 2-bit addition wraps modulo 4; k = 4 lands back on ptr_i itself.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = ptr_i + 2'(k);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/tlc5620_ch_sched.sv
// -----------------------------------------------------------------------------
// tlc5620_ch_sched
// Shares one TLC5620 quad serial DAC among four requesters. A round-robin
// winner is acknowledged, its 11-bit frame (A1 A0 RNG D7..D0) is shifted out
// MSB first, LOAD is pulsed, and a gap is inserted before the next frame.
// Optional feature (macro TLC5620_SIMUL_UPDATE_EN): LDAC idles high and is
// pulsed once after the gap when no request is pending, so every channel
// written in a burst updates together. Without it LDAC is tied low.
// Parameters:
//   CLK_DIV : clk cycles per DAC clock half-period (2..255)
//   GAP_CYC : idle cycles after LOAD (1..255)
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   req  [3:0]     : per-channel request (bit i = DAC channel i)
//   code [31:0]    : per-channel code, channel i at [8i+7:8i]
//   rng  [3:0]     : per-channel range bit
//   ack  [3:0]     : one-cycle one-hot grant; code/rng captured here
//   busy           : high from the ack cycle until back in IDLE
//   done           : one-cycle pulse on the last gap cycle
//   dac_clk, dac_data, load, ldac : TLC5620 pins (load/ldac active-low)
//   last_code [31:0]: last code sent per channel (display path)
// -----------------------------------------------------------------------------
module tlc5620_ch_sched
    import tlc5620_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   req,
    input  logic [8*NUM_CH-1:0] code,
    input  logic [NUM_CH-1:0]   rng,
    output logic [NUM_CH-1:0]   ack,
    output logic                busy,
    output logic                done,
    output logic                dac_clk,
    output logic                dac_data,
    output logic                load,
    output logic                ldac,
    output logic [8*NUM_CH-1:0] last_code
);

    // Wide enough for one full bit period (2*255-1).
    localparam int CNT_W = 9;

    localparam logic [CNT_W-1:0]     BIT_LAST     = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0]     HALF         = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0]     DIV_LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_IDX_LAST = BIT_CNT_W'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [NUM_CH-1:0]       ack_q, ack_d;
    logic [8*NUM_CH-1:0]     last_code_q, last_code_d;

    logic [NUM_CH-1:0]       arb_gnt;
    logic                    arb_valid;
    logic [1:0]              g_idx;
    logic                    start;
    logic                    shift_end;

    tlc5620_rr_arb4 u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    assign g_idx     = onehot_to_idx(arb_gnt);
    // Requests are only looked at in IDLE; anything seen elsewhere is ignored.
    assign start     = (state_q == ST_IDLE) && arb_valid;
    assign shift_end = (state_q == ST_SHIFT) && (cnt_q == BIT_LAST);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: last_code is reset along with the control state so the display
    // path shows a defined value before the first frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            ptr_q       <= CH_D;
            ack_q       <= '0;
            last_code_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            ptr_q       <= ptr_d;
            ack_q       <= ack_d;
            last_code_q <= last_code_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_valid) state_d = ST_SHIFT;
            ST_SHIFT: if (shift_end && bit_q == BIT_IDX_LAST) state_d = ST_LOAD;
            ST_LOAD:  if (cnt_q == DIV_LAST) state_d = ST_GAP;
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
`ifdef TLC5620_SIMUL_UPDATE_EN
                    // Defer the output update while more frames are queued.
                    state_d = (req == '0) ? ST_LDAC : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef TLC5620_SIMUL_UPDATE_EN
            ST_LDAC:  if (cnt_q == DIV_LAST) state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        frame_d     = frame_q;
        ptr_d       = ptr_q;
        ack_d       = '0;
        last_code_d = last_code_q;

        // One counter serves every state: it restarts on each state change
        // and, in SHIFT, at every bit boundary.
        if (state_d != state_q || state_q == ST_IDLE || shift_end) begin
            cnt_d = '0;
        end

        if (state_q != ST_SHIFT) begin
            bit_d = '0;
        end else if (shift_end) begin
            bit_d = bit_q + 1'b1;
        end

        if (start) begin
            // Frame is captured on entry to SHIFT so A1 is already on the
            // data pin during the ack cycle.
            frame_d                          = pack_frame(g_idx, rng[g_idx],
                                                          code[{g_idx, 3'b000} +: 8]);
            ptr_d                            = g_idx;
            ack_d                            = arb_gnt;
            last_code_d[{g_idx, 3'b000} +: 8] = code[{g_idx, 3'b000} +: 8];
        end else if (shift_end) begin
            // Shift at the end of a bit: data moves on the DAC clock rising
            // edge, never on the falling (sampling) edge.
            frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        dac_clk  = 1'b1;
        dac_data = 1'b0;
        load     = 1'b1;
`ifdef TLC5620_SIMUL_UPDATE_EN
        ldac     = 1'b1;
`else
        ldac     = 1'b0;
`endif
        done     = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_SHIFT: begin
                dac_clk  = (cnt_q < HALF);
                dac_data = frame_q[FRAME_BITS-1];
            end
            ST_LOAD:  load = 1'b0;
            ST_GAP:   done = (cnt_q == GAP_LAST);
`ifdef TLC5620_SIMUL_UPDATE_EN
            ST_LDAC:  ldac = 1'b0;
`endif
            default:  ;
        endcase
    end

    assign ack       = ack_q;
    assign last_code = last_code_q;

endmodule

// File: tb/tb_tlc5620_ch_sched.sv
// -----------------------------------------------------------------------------
// tb_tlc5620_ch_sched
// Self-checking bench for tlc5620_ch_sched. dut runs at CLK_DIV=4/GAP_CYC=4,
// dut2 at the CLK_DIV=2/GAP_CYC=3 corner. Pin activity is logged on the
// falling system-clock edge and compared against a frame/round-robin model.
// Honours TLC5620_SIMUL_UPDATE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_tlc5620_ch_sched;

    localparam int TB_DIV  = 4;
    localparam int TB_GAP  = 4;
    localparam int TB_DIV2 = 2;
    localparam int TB_GAP2 = 3;
    // ack to first IDLE cycle
    localparam int FRAME_CYC  = 23 * TB_DIV + TB_GAP;
    localparam int FRAME_CYC2 = 23 * TB_DIV2 + TB_GAP2;
`ifdef TLC5620_SIMUL_UPDATE_EN
    localparam logic LDAC_IDLE  = 1'b1;
    localparam int   LDAC_EXTRA = TB_DIV;
`else
    localparam logic LDAC_IDLE  = 1'b0;
    localparam int   LDAC_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req2;
    logic [31:0] code;
    logic [3:0]  rng;
    logic [3:0]  ack, ack2;
    logic        busy, done, dac_clk, dac_data, load, ldac;
    logic        busy2, done2, dclk2, ddata2, load2, ldac2;
    logic [31:0] last_code, lcode2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tlc5620_ch_sched #(.CLK_DIV(TB_DIV), .GAP_CYC(TB_GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .code(code), .rng(rng),
        .ack(ack), .busy(busy), .done(done), .dac_clk(dac_clk),
        .dac_data(dac_data), .load(load), .ldac(ldac), .last_code(last_code)
    );

    tlc5620_ch_sched #(.CLK_DIV(TB_DIV2), .GAP_CYC(TB_GAP2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .code(code), .rng(rng),
        .ack(ack2), .busy(busy2), .done(done2), .dac_clk(dclk2),
        .dac_data(ddata2), .load(load2), .ldac(ldac2), .last_code(lcode2)
    );

    // ---------------- pin monitors (sampled on negedge) ----------------
    int cyc = 0;
    int ack_ch_q[$], ack_cyc_q[$], fall_cyc_q[$], done_cyc_q[$], busy_fall_q[$], ldac_fall_q[$];
    bit bits_q[$];
    int load_low, load_pulses, ldac_low, ldac_high, data_fall_err;
    logic p_clk = 1'b1, p_data = 1'b0, p_load = 1'b1, p_busy = 1'b0, p_ldac = 1'b0;

    int ack2_cyc_q[$], fall2_q[$], done2_q[$];
    bit bits2_q[$];
    int data_fall_err2;
    logic p_clk2 = 1'b1, p_data2 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (ack[i] === 1'b1) begin
                ack_ch_q.push_back(i);
                ack_cyc_q.push_back(cyc);
            end
        end
        if (p_clk === 1'b1 && dac_clk === 1'b0) begin
            bits_q.push_back(dac_data);
            fall_cyc_q.push_back(cyc);
            if (dac_data !== p_data) data_fall_err++;
        end
        if (load === 1'b0) load_low++;
        if (p_load === 1'b1 && load === 1'b0) load_pulses++;
        if (done === 1'b1) done_cyc_q.push_back(cyc);
        if (p_busy === 1'b1 && busy === 1'b0) busy_fall_q.push_back(cyc);
        if (ldac === 1'b0) ldac_low++; else ldac_high++;
        if (p_ldac === 1'b1 && ldac === 1'b0) ldac_fall_q.push_back(cyc);
        p_clk = dac_clk; p_data = dac_data; p_load = load; p_busy = busy; p_ldac = ldac;

        if (ack2 !== 4'b0) ack2_cyc_q.push_back(cyc);
        if (p_clk2 === 1'b1 && dclk2 === 1'b0) begin
            bits2_q.push_back(ddata2);
            fall2_q.push_back(cyc);
            if (ddata2 !== p_data2) data_fall_err2++;
        end
        if (done2 === 1'b1) done2_q.push_back(cyc);
        p_clk2 = dclk2; p_data2 = ddata2;
    end

    // ---------------- reference model ----------------
    int         mdl_ptr = 3;
    logic [7:0] mdl_last [4];

    function automatic int mdl_pick(input logic [3:0] pend);
        for (int k = 1; k <= 4; k++) begin
            int c = (mdl_ptr + k) % 4;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    function automatic int exp_word(input int ch, input int r, input int c);
        return ch * 512 + r * 256 + c;
    endfunction

    function automatic logic [31:0] mdl_last_packed();
        return {mdl_last[3], mdl_last[2], mdl_last[1], mdl_last[0]};
    endfunction

    function automatic int word_at(input bit q[$], input int f);
        int w = 0;
        for (int k = 0; k < 11; k++) w = (w << 1) | int'(q[f * 11 + k]);
        return w;
    endfunction

    task automatic mdl_reset();
        mdl_ptr = 3;
        for (int i = 0; i < 4; i++) mdl_last[i] = 8'h00;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_ch_q.delete(); ack_cyc_q.delete(); fall_cyc_q.delete(); done_cyc_q.delete();
        busy_fall_q.delete(); ldac_fall_q.delete(); bits_q.delete();
        load_low = 0; load_pulses = 0; ldac_low = 0; ldac_high = 0; data_fall_err = 0;
        ack2_cyc_q.delete(); fall2_q.delete(); done2_q.delete(); bits2_q.delete();
        data_fall_err2 = 0;
    endtask

    // Requesters post 'mask' together and each drops its bit on its ack.
    task automatic serve(input logic [3:0] mask, input int max_cyc, output bit timed_out);
        logic [3:0] pend;
        int n;
        pend = mask;
        n = 0;
        req = mask;
        while (pend != 4'b0 && n < max_cyc) begin
            step(); n++;
            pend = pend & ~ack;
            req = pend;
        end
        while (busy !== 1'b0 && n < max_cyc) begin
            step(); n++;
        end
        timed_out = (n >= max_cyc);
        req = 4'b0;
        repeat (2) step();
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        mdl_reset();
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; req = 4'b0; req2 = 4'b0; code = 32'h0; rng = 4'b0;
        mdl_reset();
        repeat (3) step();
        n_checks++;
        if ({dac_clk, dac_data, load} !== 3'b101)
            $display("FAIL reset_pins: got clk/data/load=%b expected 101", {dac_clk, dac_data, load});
        else n_pass++;
        n_checks++;
        if (ldac !== LDAC_IDLE) $display("FAIL reset_ldac: got %b expected %b", ldac, LDAC_IDLE);
        else n_pass++;
        n_checks++;
        if ({ack, busy, done} !== 6'b0) $display("FAIL reset_ctrl: got ack/busy/done=%b expected 0", {ack, busy, done});
        else n_pass++;
        n_checks++;
        if (last_code !== 32'h0) $display("FAIL reset_last_code: got %h expected 0", last_code);
        else n_pass++;
        n_checks++;
        if ({dclk2, ddata2, load2, busy2} !== 4'b1010)
            $display("FAIL reset_dut2: got %b expected 1010", {dclk2, ddata2, load2, busy2});
        else n_pass++;
        rst = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_single();
        bit to;
        int ok;
        clear_logs();
        code = 32'h0; code[23:16] = 8'hA5; rng = 4'b0100;
        serve(4'b0100, 400, to);
        mdl_ptr = 2; mdl_last[2] = 8'hA5;
        n_checks++;
        if (to) $display("FAIL single_timeout: busy never dropped");
        else n_pass++;
        n_checks++;
        if (ack_ch_q.size() != 1 || ack_ch_q[0] != 2)
            $display("FAIL single_ack: got %0d acks (first ch %0d) expected 1 ack on ch 2",
                     ack_ch_q.size(), ack_ch_q.size() > 0 ? ack_ch_q[0] : -1);
        else n_pass++;
        n_checks++;
        if (bits_q.size() != 11 || word_at(bits_q, 0) != exp_word(2, 1, 8'hA5))
            $display("FAIL single_frame: got %0d bits word %h expected 11 bits word %h",
                     bits_q.size(), word_at(bits_q, 0), exp_word(2, 1, 8'hA5));
        else n_pass++;
        n_checks++;
        if (load_low != TB_DIV || load_pulses != 1)
            $display("FAIL single_load: got %0d low cycles in %0d pulses expected %0d in 1",
                     load_low, load_pulses, TB_DIV);
        else n_pass++;
        n_checks++;
        if (done_cyc_q.size() != 1 || ack_cyc_q.size() != 1 || done_cyc_q[0] - ack_cyc_q[0] != FRAME_CYC - 1)
            $display("FAIL single_done: got %0d done pulses, offset %0d expected 1 at %0d",
                     done_cyc_q.size(), done_cyc_q.size() > 0 && ack_cyc_q.size() > 0 ?
                     done_cyc_q[0] - ack_cyc_q[0] : -1, FRAME_CYC - 1);
        else n_pass++;
        n_checks++;
        if (busy_fall_q.size() != 1 || ack_cyc_q.size() != 1 || busy_fall_q[0] - ack_cyc_q[0] != FRAME_CYC + LDAC_EXTRA)
            $display("FAIL single_busy: got busy drop offset %0d expected %0d",
                     busy_fall_q.size() > 0 && ack_cyc_q.size() > 0 ? busy_fall_q[0] - ack_cyc_q[0] : -1,
                     FRAME_CYC + LDAC_EXTRA);
        else n_pass++;
        n_checks++;
        if (fall_cyc_q.size() == 0 || ack_cyc_q.size() == 0 || fall_cyc_q[0] - ack_cyc_q[0] != TB_DIV)
            $display("FAIL single_first_fall: got offset %0d expected %0d",
                     fall_cyc_q.size() > 0 && ack_cyc_q.size() > 0 ? fall_cyc_q[0] - ack_cyc_q[0] : -1, TB_DIV);
        else n_pass++;
        ok = 1;
        for (int i = 1; i < fall_cyc_q.size(); i++)
            if (fall_cyc_q[i] - fall_cyc_q[i-1] != 2 * TB_DIV) ok = 0;
        n_checks++;
        if (ok == 0 || data_fall_err != 0)
            $display("FAIL single_bit_timing: period_ok=%0d data_at_fall_changes=%0d expected 1 and 0", ok, data_fall_err);
        else n_pass++;
        n_checks++;
        if (last_code !== mdl_last_packed())
            $display("FAIL single_last_code: got %h expected %h", last_code, mdl_last_packed());
        else n_pass++;
        n_checks++;
`ifdef TLC5620_SIMUL_UPDATE_EN
        if (ldac_low != TB_DIV || ldac_fall_q.size() != 1)
            $display("FAIL single_ldac: got %0d low cycles in %0d pulses expected %0d in 1",
                     ldac_low, ldac_fall_q.size(), TB_DIV);
        else n_pass++;
`else
        if (ldac_high != 0) $display("FAIL single_ldac: got %0d high cycles expected 0", ldac_high);
        else n_pass++;
`endif
    endtask

    task automatic test_round_robin();
        int n;
        pulse_reset();
        clear_logs();
        code = {8'h44, 8'h33, 8'h22, 8'h11};
        rng = 4'($urandom);
        req = 4'hF;
        n = 0;
        while (ack_ch_q.size() < 5 && n < 800) begin step(); n++; end
        req = 4'h0;
        while (busy !== 1'b0 && n < 1000) begin step(); n++; end
        repeat (2) step();
        n_checks++;
        if (ack_ch_q.size() != 5)
            $display("FAIL rr_count: got %0d acks expected 5", ack_ch_q.size());
        else n_pass++;
        for (int f = 0; f < 5 && f < ack_ch_q.size(); f++) begin
            int c;
            c = mdl_pick(4'hF);
            mdl_ptr = c;
            mdl_last[c] = code[8*c +: 8];
            n_checks++;
            if (ack_ch_q[f] != c || bits_q.size() < 11 * (f + 1) ||
                word_at(bits_q, f) != exp_word(c, int'(rng[c]), int'(code[8*c +: 8])))
                $display("FAIL rr_frame%0d: got ch %0d word %h expected ch %0d word %h", f, ack_ch_q[f],
                         bits_q.size() >= 11 * (f + 1) ? word_at(bits_q, f) : -1,
                         c, exp_word(c, int'(rng[c]), int'(code[8*c +: 8])));
            else n_pass++;
            if (f > 0) begin
                n_checks++;
                if (ack_cyc_q[f] - ack_cyc_q[f-1] != FRAME_CYC + 1)
                    $display("FAIL rr_spacing%0d: got %0d expected %0d", f,
                             ack_cyc_q[f] - ack_cyc_q[f-1], FRAME_CYC + 1);
                else n_pass++;
            end
        end
        n_checks++;
        if (load_pulses != 5 || data_fall_err != 0)
            $display("FAIL rr_loads: got %0d load pulses, %0d data changes at fall expected 5 and 0",
                     load_pulses, data_fall_err);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        int n;
        clear_logs();
        code[7:0] = 8'($urandom);
        rng = 4'($urandom);
        req = 4'b0001;
        n = 0;
        while (ack[0] !== 1'b1 && n < 20) begin step(); n++; end
        req = 4'b0000;
        repeat (10) step();
        req = 4'b0010;
        repeat (60) step();
        req = 4'b0000;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin step(); n++; end
        repeat (20) step();
        mdl_ptr = 0; mdl_last[0] = code[7:0];
        n_checks++;
        if (ack_ch_q.size() != 1 || ack_ch_q[0] != 0)
            $display("FAIL withdraw_acks: got %0d acks expected 1 on ch 0", ack_ch_q.size());
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL withdraw_busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (bits_q.size() != 11 || word_at(bits_q, 0) != exp_word(0, int'(rng[0]), int'(code[7:0])))
            $display("FAIL withdraw_frame: got %0d bits word %h expected 11 bits word %h", bits_q.size(),
                     word_at(bits_q, 0), exp_word(0, int'(rng[0]), int'(code[7:0])));
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        bit to;
        clear_logs();
        code[31:24] = 8'($urandom);
        req = 4'b1000;
        n = 0;
        while (ack[3] !== 1'b1 && n < 20) begin step(); n++; end
        req = 4'b0000;
        while (bits_q.size() < 5 && n < 200) begin step(); n++; end
        n_checks++;
        if (bits_q.size() < 5) $display("FAIL midrst_wait: got %0d falls expected 5", bits_q.size());
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({dac_clk, load, busy, dac_data, ack} !== 8'b1100_0000)
            $display("FAIL midrst_pins: got clk/load/busy/data/ack=%b expected 11000000",
                     {dac_clk, load, busy, dac_data, ack});
        else n_pass++;
        n_checks++;
        if (load_pulses != 0 || last_code !== 32'h0)
            $display("FAIL midrst_discard: got %0d load pulses last_code %h expected 0 and 0",
                     load_pulses, last_code);
        else n_pass++;
        repeat (3) step();
        rst = 1'b1;
        mdl_reset();
        step();
        clear_logs();
        code = 32'($urandom);
        rng = 4'($urandom);
        serve(4'b1001, 600, to);
        n_checks++;
        if (to || ack_ch_q.size() != 2 || ack_ch_q[0] != 0 || ack_ch_q[1] != 3)
            $display("FAIL midrst_order: got %0d acks first ch %0d expected 2 acks ch 0 then 3",
                     ack_ch_q.size(), ack_ch_q.size() > 0 ? ack_ch_q[0] : -1);
        else n_pass++;
        mdl_ptr = 3; mdl_last[0] = code[7:0]; mdl_last[3] = code[31:24];
        n_checks++;
        if (bits_q.size() != 22 || word_at(bits_q, 1) != exp_word(3, int'(rng[3]), int'(code[31:24])))
            $display("FAIL midrst_frame: got %0d bits word %h expected 22 bits word %h", bits_q.size(),
                     word_at(bits_q, 1), exp_word(3, int'(rng[3]), int'(code[31:24])));
        else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 5; it++) begin
            logic [3:0] mask, pend;
            int nbits;
            mask = 4'($urandom_range(1, 15));
            code = 32'($urandom);
            rng  = 4'($urandom);
            clear_logs();
            serve(mask, 2000, to);
            nbits = $countones(mask);
            n_checks++;
            if (to || ack_ch_q.size() != nbits || bits_q.size() != 11 * nbits)
                $display("FAIL rand%0d_count: got %0d acks %0d bits expected %0d acks", it,
                         ack_ch_q.size(), bits_q.size(), nbits);
            else n_pass++;
            pend = mask;
            for (int f = 0; f < nbits && f < ack_ch_q.size(); f++) begin
                int c;
                c = mdl_pick(pend);
                pend[c] = 1'b0;
                mdl_ptr = c;
                mdl_last[c] = code[8*c +: 8];
                n_checks++;
                if (ack_ch_q[f] != c || bits_q.size() < 11 * (f + 1) ||
                    word_at(bits_q, f) != exp_word(c, int'(rng[c]), int'(code[8*c +: 8])))
                    $display("FAIL rand%0d_frame%0d: got ch %0d expected ch %0d word %h", it, f,
                             ack_ch_q[f], c, exp_word(c, int'(rng[c]), int'(code[8*c +: 8])));
                else n_pass++;
            end
        end
        n_checks++;
        if (last_code !== mdl_last_packed())
            $display("FAIL rand_last_code: got %h expected %h", last_code, mdl_last_packed());
        else n_pass++;
    endtask

    task automatic test_ldac_update();
        bit to;
        clear_logs();
        code = 32'($urandom);
        serve(4'b1001, 600, to);
        n_checks++;
        if (to || load_pulses != 2 || ack_cyc_q.size() != 2)
            $display("FAIL ldac_loads: got %0d load pulses %0d acks expected 2 and 2", load_pulses, ack_cyc_q.size());
        else n_pass++;
        n_checks++;
`ifdef TLC5620_SIMUL_UPDATE_EN
        if (ldac_fall_q.size() != 1 || ldac_low != TB_DIV || ack_cyc_q.size() != 2 ||
            ldac_fall_q[0] - ack_cyc_q[1] != FRAME_CYC)
            $display("FAIL ldac_pulse: got %0d pulses %0d low cycles expected 1 pulse of %0d at +%0d",
                     ldac_fall_q.size(), ldac_low, TB_DIV, FRAME_CYC);
        else n_pass++;
`else
        if (ldac_high != 0) $display("FAIL ldac_static: got %0d high cycles expected 0", ldac_high);
        else n_pass++;
`endif
        for (int k = 0; k < 2; k++) begin
            int c;
            c = mdl_pick(4'b1001 & ~(k == 1 ? 4'(1 << mdl_ptr) : 4'b0));
            mdl_ptr = c;
            mdl_last[c] = code[8*c +: 8];
        end
        n_checks++;
        if (last_code !== mdl_last_packed())
            $display("FAIL ldac_last_code: got %h expected %h", last_code, mdl_last_packed());
        else n_pass++;
    endtask

    task automatic test_clkdiv2();
        int n, ok;
        clear_logs();
        code = 32'($urandom);
        rng  = 4'($urandom);
        req2 = 4'b0010;
        n = 0;
        while (ack2[1] !== 1'b1 && n < 20) begin step(); n++; end
        req2 = 4'b0000;
        while (busy2 !== 1'b0 && n < 200) begin step(); n++; end
        repeat (2) step();
        n_checks++;
        if (bits2_q.size() != 11 || word_at(bits2_q, 0) != exp_word(1, int'(rng[1]), int'(code[15:8])))
            $display("FAIL div2_frame: got %0d bits word %h expected 11 bits word %h", bits2_q.size(),
                     word_at(bits2_q, 0), exp_word(1, int'(rng[1]), int'(code[15:8])));
        else n_pass++;
        ok = 1;
        for (int i = 1; i < fall2_q.size(); i++)
            if (fall2_q[i] - fall2_q[i-1] != 2 * TB_DIV2) ok = 0;
        n_checks++;
        if (ok == 0 || fall2_q.size() != 11)
            $display("FAIL div2_period: got period_ok=%0d falls=%0d expected 1 and 11", ok, fall2_q.size());
        else n_pass++;
        n_checks++;
        if (data_fall_err2 != 0)
            $display("FAIL div2_data_at_fall: got %0d changes expected 0", data_fall_err2);
        else n_pass++;
        n_checks++;
        if (ack2_cyc_q.size() != 1 || done2_q.size() != 1 || done2_q[0] - ack2_cyc_q[0] != FRAME_CYC2 - 1 ||
            fall2_q.size() == 0 || fall2_q[0] - ack2_cyc_q[0] != TB_DIV2)
            $display("FAIL div2_timing: got done offset %0d expected %0d, first fall expected +%0d",
                     done2_q.size() > 0 && ack2_cyc_q.size() > 0 ? done2_q[0] - ack2_cyc_q[0] : -1,
                     FRAME_CYC2 - 1, TB_DIV2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_reset_mid_frame();
        test_random();
        test_ldac_update();
        test_clkdiv2();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
